// File: rtl/iir_stream_sequencer_pkg.sv
// Shared definitions for the IIR stream sequencer slice.
//   - seq_state_t    : sequencer FSM states
//   - OPSIZE_DEFAULT : default sample width
//   - Q_ONE_MAX / Q_NEG_ONE : Q1.15 extreme values
package iir_pkg;

  localparam int unsigned OPSIZE_DEFAULT = 16;

  localparam logic [15:0] Q_ONE_MAX = 16'h7FFF;
  localparam logic [15:0] Q_NEG_ONE = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/iir_stream_sequencer_if.sv
// Stream and filter-handshake bundle for iir_stream_sequencer.
//   s_valid/s_ready/s_data : input sample stream
//   m_valid/m_ready/m_data : filtered output stream
//   filt_start/filt_xin    : issue side towards the filter core
//   filt_ready/filt_yout   : filter idle/result side
// master = sequencer view, slave = surrounding environment view.
interface iir_stream_sequencer_if #(
  parameter int unsigned OPSIZE = 16
);

  logic              s_valid;
  logic              s_ready;
  logic [OPSIZE-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [OPSIZE-1:0] m_data;
  logic              filt_start;
  logic [OPSIZE-1:0] filt_xin;
  logic              filt_ready;
  logic [OPSIZE-1:0] filt_yout;

  modport master (
    input  s_valid, s_data, m_ready, filt_ready, filt_yout,
    output s_ready, m_valid, m_data, filt_start, filt_xin
  );

  modport slave (
    output s_valid, s_data, m_ready, filt_ready, filt_yout,
    input  s_ready, m_valid, m_data, filt_start, filt_xin
  );

endinterface

// File: rtl/iir_stream_sequencer_sync_fifo.sv
// sync_fifo: single-clock FIFO, synchronous active-high reset.
//   clk, reset : clock / reset (empties FIFO, pointers to 0)
//   push/wdata : write when push and not full
//   pop/rdata  : rdata shows the head combinationally; pop advances it
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int unsigned OPSIZE = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [OPSIZE-1:0]        wdata,
  input  logic                     pop,
  output logic [OPSIZE-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   C_MAX = (AW + 1)'(DEPTH);

  logic [OPSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == C_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iir_stream_sequencer.sv
// iir_stream_sequencer: feeds a non-pipelined start/ready IIR core from a
// valid/ready sample stream and returns its results on a valid/ready stream.
//   clk, reset  : clock / synchronous active-high reset
//   bus         : stream + filter handshake bundle (master view)
//   fifo_count  : input FIFO occupancy
//   busy        : a sample is in flight at the filter
//   err_timeout : sticky, set when the filter fails to finish within TIMEOUT
module iir_stream_sequencer
  import iir_pkg::*;
#(
  parameter int unsigned OPSIZE  = OPSIZE_DEFAULT,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  iir_stream_sequencer_if.master bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  seq_state_t        state;
  seq_state_t        next_state;
  logic              issue;
  logic              capture;
  logic              abort;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OPSIZE-1:0] head;
  logic [TW-1:0]     tcnt;
  logic              m_valid_q;
  logic [OPSIZE-1:0] m_data_q;
  logic              start_q;
  logic [OPSIZE-1:0] xin_q;
  logic              err_q;

  assign bus.s_ready    = !fifo_full;
  assign push           = bus.s_valid && !fifo_full;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.filt_start = start_q;
  assign bus.filt_xin   = xin_q;
  assign busy           = (state != IDLE);
  assign err_timeout    = err_q;

  sync_fifo #(
    .OPSIZE(OPSIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.s_data),
    .pop   (issue),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Issue only when the output slot is empty or draining this cycle, so a
  // captured result can never be overwritten. A result arriving on the
  // last counted cycle still wins over the timeout.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && bus.filt_ready && (!m_valid_q || bus.m_ready)) begin
          issue      = 1'b1;
          next_state = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tcnt == T_LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (!bus.filt_ready) begin
          next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.filt_ready) begin
          capture    = 1'b1;
          next_state = IDLE;
        end else if (tcnt == T_LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt      <= '0;
      start_q   <= 1'b0;
      xin_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      start_q <= issue;
      if (issue) begin
        xin_q <= head;
      end

      if (issue) begin
        tcnt <= '0;
      end else if (busy && !capture && !abort) begin
        tcnt <= tcnt + T_ONE;
      end

      if (abort) begin
        err_q <= 1'b1;
      end

      if (capture) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.filt_yout;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iir_stream_sequencer.sv
// Self-checking bench for iir_stream_sequencer with a behavioural filter
// model (ready low for 12 cycles after start, result = xin ^ 16'h00FF) and
// a queue-based scoreboard for sample order and output values.
module tb_iir_stream_sequencer;
  import iir_pkg::*;

  localparam int unsigned W       = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         s_valid = 1'b0;
  logic [W-1:0] s_data  = '0;
  logic         m_ready = 1'b0;
  logic         hang    = 1'b0;

  logic         f_ready;
  logic [W-1:0] f_yout;
  logic [W-1:0] f_x;
  int           f_cnt;
  logic         f_busy;

  logic [$clog2(DEPTH):0] fifo_count;
  logic                   busy;
  logic                   err_timeout;

  iir_stream_sequencer_if #(.OPSIZE(W)) bus ();

  assign bus.s_valid    = s_valid;
  assign bus.s_data     = s_data;
  assign bus.m_ready    = m_ready;
  assign bus.filt_ready = f_ready;
  assign bus.filt_yout  = f_yout;

  iir_stream_sequencer #(
    .OPSIZE (W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fifo_count (fifo_count),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural filter core.
  always @(posedge clk) begin
    if (reset) begin
      f_ready <= 1'b1;
      f_yout  <= '0;
      f_x     <= '0;
      f_cnt   <= 0;
      f_busy  <= 1'b0;
    end else if (bus.filt_start) begin
      f_x     <= bus.filt_xin;
      f_ready <= 1'b0;
      f_busy  <= 1'b1;
      f_cnt   <= 12;
    end else if (f_busy && !hang) begin
      if (f_cnt == 1) begin
        f_ready <= 1'b1;
        f_yout  <= f_x ^ 16'h00FF;
        f_busy  <= 1'b0;
      end else begin
        f_cnt <= f_cnt - 1;
      end
    end
  end

  // Scoreboard: accepted samples must reach the filter in order; every
  // sample that the filter completes must appear at the output as xin^00FF.
  logic [W-1:0] in_q[$];
  logic [W-1:0] exp_q[$];
  int   n_out   = 0;
  int   n_start = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] x;
    if (reset) begin
      in_q.delete();
      exp_q.delete();
      prev_start = 1'b0;
    end else begin
      if (bus.filt_start) begin
        n_start++;
        chk("start_pulse_width", prev_start, 1'b0);
        chk("start_has_sample", in_q.size() != 0, 1'b1);
        if (in_q.size() != 0) begin
          x = in_q.pop_front();
          chk("filt_xin_order", bus.filt_xin, x);
          if (!hang) exp_q.push_back(x ^ 16'h00FF);
        end
      end
      prev_start = bus.filt_start;
      if (bus.m_valid && m_ready) begin
        n_out++;
        chk("output_has_sample", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("m_data_stream", bus.m_data, exp_q.pop_front());
      end
      if (s_valid && bus.s_ready) in_q.push_back(s_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    logic saw_full;
    logic [W-1:0] b;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_filt_start", bus.filt_start, 0);
    chk("rst_filt_xin", bus.filt_xin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);

    // Single sample
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = Q_ONE_MAX;
    tick();
    s_valid = 1'b0;
    chk("t1_count_after_accept", fifo_count, 1);
    chk("t1_no_start_yet", bus.filt_start, 0);
    tick();
    chk("t1_start", bus.filt_start, 1);
    chk("t1_xin", bus.filt_xin, 16'h7FFF);
    chk("t1_busy", busy, 1);
    chk("t1_count_after_issue", fifo_count, 0);
    tick();
    chk("t1_start_cleared", bus.filt_start, 0);
    chk("t1_xin_held", bus.filt_xin, 16'h7FFF);
    k = 0;
    while (!bus.m_valid && k < 100) begin
      tick();
      k++;
    end
    chk("t1_latency", k, 13);
    chk("t1_m_data", bus.m_data, 16'h7F00);
    chk("t1_busy_after", busy, 0);
    m_ready = 1'b1;
    tick();
    chk("t1_m_valid_drained", bus.m_valid, 0);

    // Burst with input backpressure
    base     = n_out;
    saw_full = 1'b0;
    s_valid  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_data = W'(i);
      k = 0;
      while (!bus.s_ready && k < 200) begin
        if (fifo_count == 4) saw_full = 1'b1;
        tick();
        k++;
      end
      tick();
    end
    s_valid = 1'b0;
    chk("t2_backpressure_seen", saw_full, 1);
    k = 0;
    while (n_out - base < 6 && k < 2000) begin
      tick();
      k++;
    end
    chk("t2_output_count", n_out - base, 6);

    // Output stall
    m_ready = 1'b0;
    chk("t3_s_ready", bus.s_ready, 1);
    s_valid = 1'b1;
    s_data  = 16'h0011;
    tick();
    s_data  = 16'h0022;
    tick();
    s_valid = 1'b0;
    k = 0;
    while (!bus.m_valid && k < 200) begin
      tick();
      k++;
    end
    chk("t3_first_result", bus.m_data, 16'h00EE);
    base = n_start;
    for (int i = 0; i < 30; i++) tick();
    chk("t3_no_issue_while_full", n_start - base, 0);
    chk("t3_m_valid_held", bus.m_valid, 1);
    chk("t3_m_data_held", bus.m_data, 16'h00EE);
    chk("t3_count_held", fifo_count, 1);
    m_ready = 1'b1;
    tick();
    chk("t3_issue_on_release", bus.filt_start, 1);
    chk("t3_xin_on_release", bus.filt_xin, 16'h0022);
    k = 0;
    while ((busy || fifo_count != 0 || bus.m_valid) && k < 500) begin
      tick();
      k++;
    end
    chk("t3_drained", busy || bus.m_valid, 0);

    // Randomized traffic
    base = n_out;
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = W'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    k = 0;
    while ((busy || fifo_count != 0 || bus.m_valid) && k < 3000) begin
      tick();
      k++;
    end
    chk("rnd_drained", busy || bus.m_valid || (fifo_count != 0), 0);
    chk("rnd_outputs_seen", (n_out - base) > 0, 1);
    chk("rnd_in_q_empty", in_q.size(), 0);
    chk("rnd_exp_q_empty", exp_q.size(), 0);
    chk("rnd_no_timeout", err_timeout, 0);

    // Timeout
    m_ready = 1'b0;
    hang    = 1'b1;
    base    = n_out;
    s_valid = 1'b1;
    s_data  = W'($urandom);
    tick();
    s_valid = 1'b0;
    k = 0;
    while (!bus.filt_start && k < 20) begin
      tick();
      k++;
    end
    chk("t4_issued", bus.filt_start, 1);
    chk("t4_err_before", err_timeout, 0);
    k = 0;
    while (!err_timeout && k < 200) begin
      tick();
      k++;
    end
    chk("t4_timeout_cycles", k, 64);
    chk("t4_idle", busy, 0);
    chk("t4_no_output", bus.m_valid, 0);
    hang = 1'b0;
    b = W'($urandom);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
    k = 0;
    while (!bus.m_valid && k < 500) begin
      tick();
      k++;
    end
    chk("t4_recover_valid", bus.m_valid, 1);
    chk("t4_recover_data", bus.m_data, b ^ 16'h00FF);
    chk("t4_err_sticky", err_timeout, 1);
    m_ready = 1'b1;
    tick();
    chk("t4_single_output", n_out - base, 1);

    // Reset during WAIT_DONE with samples buffered
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = W'($urandom);
      tick();
    end
    s_valid = 1'b0;
    k = 0;
    while (!(fifo_count == 3 && !f_ready && busy) && k < 50) begin
      tick();
      k++;
    end
    tick();
    chk("t5_pre_count", fifo_count, 3);
    chk("t5_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_count", fifo_count, 0);
    chk("t5_m_valid", bus.m_valid, 0);
    chk("t5_m_data", bus.m_data, 0);
    chk("t5_start", bus.filt_start, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err_timeout, 0);
    chk("t5_s_ready", bus.s_ready, 1);
    base = n_out;
    k    = n_start;
    for (int i = 0; i < 60; i++) tick();
    chk("t5_no_output", n_out - base, 0);
    chk("t5_no_issue", n_start - k, 0);
    chk("t5_m_valid_after", bus.m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
